// File: rtl/ftdi_tx_arbiter.sv
// Round-robin arbiter that frames packets from NUM_REQ byte sources into one FTDI write FIFO.
// Each packet is a tagged header byte, a length byte, then the payload; starved payloads are zero-padded.
module ftdi_tx_arbiter #(
  parameter int         NUM_REQ = 3,
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter int         TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_len,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             fifo_din,
  output logic                   fifo_wr_en,
  input  logic                   fifo_prog_full,
  output logic                   busy,
  output logic [7:0]             abort_count
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, LEN, PAYLOAD, ABORT} state_t;

  state_t        state, state_next;
  logic [IW-1:0] owner, last, pick, cand;
  logic          pick_valid;
  logic [7:0]    len_cnt;
  logic [SW-1:0] starv;
  logic          xfer, starved, timeout_hit;

  // Search starts just past the previous owner, so the pointer alone decides ties.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((int'(last) + off) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    xfer        = 1'b0;
    starved     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (pick_valid) state_next = HDR;
      HDR:     if (!fifo_prog_full) state_next = LEN;
      LEN:     if (!fifo_prog_full) state_next = (len_cnt != 8'd0) ? PAYLOAD : IDLE;
      PAYLOAD: if (!fifo_prog_full) begin
        if (req_valid[owner]) begin
          xfer = 1'b1;
          if (len_cnt <= 8'd1) state_next = IDLE;
        end else begin
          starved = 1'b1;
          if (starv == SW'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_next  = ABORT;
          end
        end
      end
      ABORT:   if (!fifo_prog_full && len_cnt <= 8'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!res_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      grant       <= '0;
      owner       <= '0;
      last        <= IW'(NUM_REQ - 1);
      len_cnt     <= '0;
      starv       <= '0;
      fifo_din    <= '0;
      fifo_wr_en  <= 1'b0;
      abort_count <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (state == IDLE && pick_valid) begin
        grant   <= NUM_REQ'(1) << pick;
        owner   <= pick;
        len_cnt <= req_len[8*int'(pick) +: 8];
        starv   <= '0;
      end
      if (state == HDR && !fifo_prog_full) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= {HDR_TAG, 2'b00, 2'(owner)};
      end
      if (state == LEN && !fifo_prog_full) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= len_cnt;
      end
      if (xfer) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= req_data[8*int'(owner) +: 8];
        len_cnt    <= len_cnt - 8'd1;
        starv      <= '0;
      end
      if (starved) starv <= timeout_hit ? '0 : starv + 1'b1;
      if (timeout_hit && abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
      // Padding keeps the downstream framing intact: the length byte already promised len_cnt bytes.
      if (state == ABORT && !fifo_prog_full) begin
        fifo_wr_en <= 1'b1;
        fifo_din   <= 8'h00;
        len_cnt    <= len_cnt - 8'd1;
      end
      if (state != IDLE && state_next == IDLE) begin
        grant <= '0;
        last  <= owner;
      end
    end
  end

  assign req_ready = (state == PAYLOAD && !fifo_prog_full) ? grant : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Bench for ftdi_tx_arbiter: directed scenarios plus randomized rounds, scored against a
// packet-level model (round-robin order, header/length/payload byte stream, abort padding).
module tb_ftdi_tx_arbiter;
  localparam int         NUM_REQ = 3;
  localparam int         TIMEOUT = 255;
  localparam logic [3:0] HDR_TAG = 4'hA;

  logic                 clk = 1'b0;
  logic                 res_n;
  logic [NUM_REQ-1:0]   req, req_valid, req_ready, grant;
  logic [8*NUM_REQ-1:0] req_len, req_data;
  logic [7:0]           fifo_din, abort_count;
  logic                 fifo_wr_en, fifo_prog_full, busy;

  ftdi_tx_arbiter #(.NUM_REQ(NUM_REQ), .HDR_TAG(HDR_TAG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .res_n(res_n), .req(req), .req_len(req_len), .req_data(req_data),
    .req_valid(req_valid), .req_ready(req_ready), .grant(grant), .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en), .fifo_prog_full(fifo_prog_full), .busy(busy),
    .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, grant_rises = 0, model_last = NUM_REQ - 1;
  int unsigned valid_pct = 100;
  bit pf_rand = 0, pf_force = 0, one_shot = 1, prev_pf = 0;
  logic [NUM_REQ-1:0] prev_grant = '0, ready_seen = '0;
  logic [7:0] src_q [NUM_REQ][$];
  logic [7:0] exp_q [$];
  logic [7:0] wr_byte [$];
  int         wr_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src_q[i].size() > 0) && ($urandom_range(0, 99) < valid_pct);
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom);
    end
  endtask

  // One clock: observe at the falling edge, update sources just after the rising edge.
  task automatic tick();
    logic [NUM_REQ-1:0] fired;
    @(negedge clk);
    cyc++;
    if (fifo_wr_en) begin
      wr_byte.push_back(fifo_din);
      wr_cyc.push_back(cyc);
    end
    if (prev_pf) check("wr_during_stall", 32'(fifo_wr_en), 0);
    if (fifo_prog_full) check("ready_during_stall", 32'(req_ready), 0);
    if (req_ready != 0) check("ready_not_owner", 32'(req_ready & ~grant), 0);
    ready_seen |= req_ready;
    if (grant != 0 && prev_grant == 0) grant_rises++;
    prev_grant = grant;
    prev_pf    = fifo_prog_full;
    fired      = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (one_shot) req &= ~grant;
    fifo_prog_full = pf_rand ? ($urandom_range(0, 3) == 0) : pf_force;
    drive_sources();
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++)
      if (mask[(model_last + k) % NUM_REQ]) return (model_last + k) % NUM_REQ;
    return 0;
  endfunction

  task automatic expect_pkt(input int r, input int len);
    logic [7:0] b;
    exp_q.push_back({HDR_TAG, 4'(r)});
    exp_q.push_back(8'(len));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      src_q[r].push_back(b);
      exp_q.push_back(b);
    end
    model_last = r;
  endtask

  task automatic clear_logs();
    wr_byte.delete();
    wr_cyc.delete();
    exp_q.delete();
    ready_seen  = '0;
    grant_rises = 0;
  endtask

  task automatic start_round(input logic [NUM_REQ-1:0] mask, input int lens[NUM_REQ]);
    logic [NUM_REQ-1:0] pend;
    int r;
    clear_logs();
    pend = mask;
    for (int i = 0; i < NUM_REQ; i++) req_len[8*i +: 8] = 8'(lens[i]);
    req = mask;
    while (pend != 0) begin
      r = rr_pick(pend);
      expect_pkt(r, lens[r]);
      pend &= ~(NUM_REQ'(1) << r);
    end
  endtask

  task automatic finish_round(input string tag, input int budget);
    int n = 0;
    while (wr_byte.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_count"}, wr_byte.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_byte.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), wr_byte[k], exp_q[k]);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_grant_after"}, 32'(grant), 0);
  endtask

  initial begin
    int n, sz;
    int lens[NUM_REQ];
    res_n = 1'b0; req = '0; req_len = '0; req_data = '0; req_valid = '0; fifo_prog_full = 1'b0;
    #12;
    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_din", 32'(fifo_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_abort_count", 32'(abort_count), 0);
    @(posedge clk); #1;
    res_n = 1'b1;
    tick();

    // Round-robin with all requests held: A0, A1, A2, A0.
    clear_logs();
    one_shot = 0;
    req_len  = {8'd1, 8'd1, 8'd1};
    req      = '1;
    for (int k = 0; k < 4; k++) expect_pkt(rr_pick('1), 1);
    n = 0;
    while (grant_rises < 4 && n < 100) begin tick(); n++; end
    req      = '0;
    one_shot = 1;
    finish_round("rr", 200);
    if (wr_byte.size() >= 10) begin
      check("rr_hdr0", wr_byte[0], 8'hA0);
      check("rr_hdr1", wr_byte[3], 8'hA1);
      check("rr_hdr2", wr_byte[6], 8'hA2);
      check("rr_hdr3", wr_byte[9], 8'hA0);
    end

    // Single packet, requester 1, len 3, data every cycle.
    start_round(3'b010, '{0, 3, 0});
    finish_round("single", 100);
    if (wr_byte.size() >= 5) begin
      check("single_hdr", wr_byte[0], 8'hA1);
      check("single_len", wr_byte[1], 8'h03);
      for (int k = 1; k < 5; k++) check($sformatf("single_gap%0d", k), wr_cyc[k] - wr_cyc[k-1], 1);
    end

    // Zero-length packet: header and length only, no payload handshake.
    start_round(3'b100, '{0, 0, 0});
    finish_round("zero", 100);
    check("zero_ready_seen", 32'(ready_seen), 0);
    if (wr_byte.size() >= 2) check("zero_hdr", wr_byte[0], 8'hA2);

    // Back-pressure held for 10 cycles mid-payload.
    start_round(3'b010, '{0, 6, 0});
    n = 0;
    while (wr_byte.size() < 4 && n < 50) begin tick(); n++; end
    pf_force = 1;
    tick(); tick();
    sz = wr_byte.size();
    ready_seen = '0;
    repeat (9) tick();
    check("bp_no_writes", wr_byte.size(), sz);
    check("bp_no_ready", 32'(ready_seen), 0);
    pf_force = 0;
    finish_round("bp", 100);

    // Timeout: one byte of four arrives, then the source goes silent.
    clear_logs();
    req_len = {8'd0, 8'd0, 8'd4};
    req     = 3'b001;
    exp_q.push_back({HDR_TAG, 4'd0});
    exp_q.push_back(8'd4);
    src_q[0].push_back(8'h5C);
    exp_q.push_back(8'h5C);
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
    model_last = 0;
    finish_round("timeout", 600);
    check("timeout_abort_count", 32'(abort_count), 1);
    if (wr_cyc.size() >= 4) check("timeout_gap", wr_cyc[3] - wr_cyc[2], TIMEOUT + 1);

    // Randomized rounds with random masks, lengths, source gaps and back-pressure.
    pf_rand = 1;
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int i = 0; i < NUM_REQ; i++) lens[i] = $urandom_range(0, 6);
      valid_pct = $urandom_range(40, 100);
      start_round(NUM_REQ'($urandom_range(1, 7)), lens);
      finish_round($sformatf("rand%0d", rnd), 500);
    end
    pf_rand   = 0;
    valid_pct = 100;
    tick();

    // Reset pulse in the middle of a payload.
    start_round(3'b010, '{0, 8, 0});
    n = 0;
    while (wr_byte.size() < 4 && n < 50) begin tick(); n++; end
    #2 res_n = 1'b0;
    #1;
    check("midrst_grant", 32'(grant), 0);
    check("midrst_ready", 32'(req_ready), 0);
    check("midrst_wr_en", 32'(fifo_wr_en), 0);
    check("midrst_din", 32'(fifo_din), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_abort_count", 32'(abort_count), 0);
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    model_last = NUM_REQ - 1;
    @(posedge clk); #1;
    res_n = 1'b1;
    prev_pf = 0;
    prev_grant = '0;
    drive_sources();
    start_round(3'b111, '{1, 1, 1});
    finish_round("post_rst", 200);
    if (wr_byte.size() >= 1) check("post_rst_first_hdr", wr_byte[0], 8'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
